// File: rtl/pcie_drp_sequencer.sv
// pcie_drp_sequencer: round-robin DRP access engine for the PCIE_2_1 hard block.
// Latency: read grant at t0, drp_en at t0+1, response the cycle after drp_rdy; RMW adds a write phase.
// Backpressure: one transaction in flight; the response is held until rsp_ready and no new grant is made until then.
// Ports: clk/sys_rst_n; req_* per-channel request bundle (valid/ready/op/addr/wdata/mask, channel-packed);
//        rsp_* shared response (valid/ready/ch/data/err); drp_* DRP master; busy = FSM not idle.
module pcie_drp_sequencer #(
  parameter  int ADDR_W  = 9,
  parameter  int DATA_W  = 16,
  parameter  int N_CH    = 2,
  parameter  int TIMEOUT = 64,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   sys_rst_n,
  input  logic [N_CH-1:0]        req_valid,
  output logic [N_CH-1:0]        req_ready,
  input  logic [2*N_CH-1:0]      req_op,
  input  logic [ADDR_W*N_CH-1:0] req_addr,
  input  logic [DATA_W*N_CH-1:0] req_wdata,
  input  logic [DATA_W*N_CH-1:0] req_mask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [CH_W-1:0]        rsp_ch,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   drp_en,
  output logic                   drp_we,
  output logic [ADDR_W-1:0]      drp_addr,
  output logic [DATA_W-1:0]      drp_di,
  input  logic [DATA_W-1:0]      drp_do,
  input  logic                   drp_rdy,
  output logic                   busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RMW = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_EN, RD_WAIT, WR_EN, WR_WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [CH_W-1:0]     rsp_ch_q, rsp_ch_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                drp_en_q, drp_en_d;
  logic                drp_we_q, drp_we_d;
  logic [ADDR_W-1:0]   drp_addr_q, drp_addr_d;
  logic [DATA_W-1:0]   drp_di_q, drp_di_d;

  // Arbiter: first valid channel at or after the round-robin pointer, with its request fields.
  logic                gnt_found;
  logic [CH_W-1:0]     gnt_idx, cand;
  logic [1:0]          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata, sel_mask;
  logic [CNT_W-1:0]    cnt_inc;
  logic                timeout_hit;
  logic [DATA_W-1:0]   merged;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    sel_op    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = (rr_q + CH_W'(i) >= CH_W'(N_CH)) ? rr_q + CH_W'(i) - CH_W'(N_CH) : rr_q + CH_W'(i);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == CH_W'(i)) begin
        sel_op    = req_op[2*i +: 2];
        sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
        sel_wdata = req_wdata[DATA_W*i +: DATA_W];
        sel_mask  = req_mask[DATA_W*i +: DATA_W];
      end
    end
  end

  // Accept strobe is combinational so the request is taken in the grant cycle itself.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_found && sys_rst_n) req_ready[gnt_idx] = 1'b1;
  end

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));
  assign merged      = (drp_do & ~mask_q) | (wdata_q & mask_q);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    rsp_valid_d = rsp_valid_q;
    rsp_ch_d    = rsp_ch_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    drp_en_d    = 1'b0;
    drp_we_d    = 1'b0;
    drp_addr_d  = drp_addr_q;
    drp_di_d    = drp_di_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          rsp_ch_d = gnt_idx;
          op_d     = sel_op;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          mask_d   = sel_mask;
          rr_d     = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
          cnt_d    = '0;
          if (sel_op == OP_RD || sel_op == OP_RMW) begin
            state_d    = RD_EN;
            drp_en_d   = 1'b1;
            drp_addr_d = sel_addr;
          end else if (sel_op == OP_WR) begin
            state_d    = WR_EN;
            drp_en_d   = 1'b1;
            drp_we_d   = 1'b1;
            drp_addr_d = sel_addr;
            drp_di_d   = sel_wdata;
          end else begin
            // Reserved op: straight to an error response, DRP untouched.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end
        end
      end
      RD_EN: state_d = RD_WAIT;
      RD_WAIT: begin
        cnt_d = cnt_inc;
        if (drp_rdy) begin
          if (op_q == OP_RMW) begin
            state_d    = WR_EN;
            wdata_d    = merged;
            cnt_d      = '0;
            drp_en_d   = 1'b1;
            drp_we_d   = 1'b1;
            drp_addr_d = addr_q;
            drp_di_d   = merged;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = drp_do;
          end
        end else if (timeout_hit) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end
      end
      WR_EN: state_d = WR_WAIT;
      WR_WAIT: begin
        cnt_d = cnt_inc;
        if (drp_rdy || timeout_hit) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !drp_rdy;
          rsp_data_d  = drp_rdy ? wdata_q : '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      drp_en_q    <= 1'b0;
      drp_we_q    <= 1'b0;
      drp_addr_q  <= '0;
      drp_di_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ch_q    <= rsp_ch_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      drp_en_q    <= drp_en_d;
      drp_we_q    <= drp_we_d;
      drp_addr_q  <= drp_addr_d;
      drp_di_q    <= drp_di_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_ch    = rsp_ch_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign drp_en    = drp_en_q;
  assign drp_we    = drp_we_q;
  assign drp_addr  = drp_addr_q;
  assign drp_di    = drp_di_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pcie_drp_sequencer.sv
// Directed bench for pcie_drp_sequencer with a small DRP slave model.
// Drives and samples on the falling clock edge; DRP model reacts on the rising edge.
// Each test task does its own inline comparisons; one summary line at the end.
module tb_pcie_drp_sequencer;
  localparam int TO = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        sys_rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req_op;
  logic [17:0] req_addr;
  logic [31:0] req_wdata, req_mask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [0:0]  rsp_ch;
  logic [15:0] rsp_data;
  logic        drp_en, drp_we, drp_rdy, busy;
  logic [8:0]  drp_addr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic        model_rdy = 1'b0;
  logic        late_rdy = 1'b0;

  assign drp_rdy = model_rdy | late_rdy;

  int errors = 0;
  int checks = 0;

  pcie_drp_sequencer #(.ADDR_W(9), .DATA_W(16), .N_CH(2), .TIMEOUT(TO)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(rsp_ch), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr), .drp_di(drp_di), .drp_do(drp_do),
    .drp_rdy(drp_rdy), .busy(busy)
  );

  // DRP slave model: memory, programmable rdy delay (cycles after drp_en), or no rdy at all.
  logic [15:0] mem [0:511];
  int          rdy_k = 1;
  bit          no_rdy = 1'b0;
  int          en_cnt = 0;
  int          wr_cnt = 0;
  int          dly = 0;
  logic [15:0] last_di = '0;
  logic [8:0]  lat_addr = '0;
  logic        pre_we = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [15:0] pre_dat = '0;

  always @(posedge clk) begin
    model_rdy <= 1'b0;
    if (pre_we) mem[pre_addr] <= pre_dat;
    if (drp_en) begin
      en_cnt   <= en_cnt + 1;
      lat_addr <= drp_addr;
      if (drp_we) begin
        wr_cnt          <= wr_cnt + 1;
        mem[drp_addr]   <= drp_di;
        last_di         <= drp_di;
      end
      if (!no_rdy) begin
        if (rdy_k <= 1) begin
          model_rdy <= 1'b1;
          drp_do    <= drp_we ? drp_di : mem[drp_addr];
        end else begin
          dly <= rdy_k - 1;
        end
      end
    end else if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        model_rdy <= 1'b1;
        drp_do    <= mem[lat_addr];
      end
    end
  end

  task automatic preset(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Present a one-cycle request; returns the accept vector seen in the grant cycle.
  // Returns at the falling edge of the cycle after the grant.
  task automatic issue(input int ch, input logic [1:0] op, input logic [8:0] a,
                       input logic [15:0] wd, input logic [15:0] mk, output logic [1:0] gnt);
    @(negedge clk);
    req_op[2*ch +: 2]     = op;
    req_addr[9*ch +: 9]   = a;
    req_wdata[16*ch +: 16] = wd;
    req_mask[16*ch +: 16]  = mk;
    req_valid[ch]         = 1'b1;
    #1 gnt = req_ready;
    @(negedge clk);
    req_valid = '0;
  endtask

  // Number of falling edges until rsp_valid, or -1 if the bound expires.
  task automatic wait_rsp(input int bound, output int n);
    n = -1;
    for (int i = 0; i <= bound; i++) begin
      if (rsp_valid === 1'b1) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0; req_mask = '0; rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    req_valid = 2'b01;
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_ch, rsp_data, rsp_err, drp_en, drp_we, drp_addr, drp_di, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs: got ready=%b vld=%b ch=%b data=%h err=%b en=%b we=%b addr=%h di=%h busy=%b, want all 0",
        req_ready, rsp_valid, rsp_ch, rsp_data, rsp_err, drp_en, drp_we, drp_addr, drp_di, busy);
    end
    req_valid = '0;
    @(negedge clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_read();
    logic [1:0] g; int n;
    preset(9'h012, 16'hBEEF);
    rdy_k = 3; rsp_ready = 1'b0;
    issue(0, 2'b00, 9'h012, 16'h0, 16'h0, g);
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL rd_grant: got %b want 01", g); end
    checks++; if ({drp_en, drp_we, drp_addr, busy} !== {1'b1, 1'b0, 9'h012, 1'b1}) begin
      errors++; $display("FAIL rd_en_cycle: got en=%b we=%b addr=%h busy=%b want 1 0 012 1", drp_en, drp_we, drp_addr, busy); end
    wait_rsp(20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL rd_latency: got rsp after %0d want 4 (t0+5)", n); end
    checks++; if ({rsp_ch, rsp_data, rsp_err} !== {1'b0, 16'hBEEF, 1'b0}) begin
      errors++; $display("FAIL rd_rsp: got ch=%0d data=%h err=%b want 0 BEEF 0", rsp_ch, rsp_data, rsp_err); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 16'hBEEF}) begin
      errors++; $display("FAIL rd_hold: got vld=%b data=%h want 1 BEEF", rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL rd_release: got vld=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_write();
    logic [1:0] g; int n; int e0, w0;
    rdy_k = 2; e0 = en_cnt; w0 = wr_cnt;
    issue(1, 2'b01, 9'h1A0, 16'h1234, 16'h0, g);
    checks++; if (g !== 2'b10) begin errors++; $display("FAIL wr_grant: got %b want 10", g); end
    checks++; if ({drp_en, drp_we, drp_addr, drp_di} !== {1'b1, 1'b1, 9'h1A0, 16'h1234}) begin
      errors++; $display("FAIL wr_en_cycle: got en=%b we=%b addr=%h di=%h want 1 1 1A0 1234", drp_en, drp_we, drp_addr, drp_di); end
    wait_rsp(20, n);
    checks++; if ({n == 3, rsp_ch, rsp_data, rsp_err} !== {1'b1, 1'b1, 16'h1234, 1'b0}) begin
      errors++; $display("FAIL wr_rsp: got n=%0d ch=%0d data=%h err=%b want 3 1 1234 0", n, rsp_ch, rsp_data, rsp_err); end
    checks++; if ((en_cnt - e0) != 1 || (wr_cnt - w0) != 1 || mem[9'h1A0] !== 16'h1234) begin
      errors++; $display("FAIL wr_drp: got en=%0d wr=%0d mem=%h want 1 1 1234", en_cnt - e0, wr_cnt - w0, mem[9'h1A0]); end
  endtask

  task automatic test_rmw();
    logic [1:0] g; int n; int e0, w0;
    preset(9'h005, 16'hFF00);
    rdy_k = 1; e0 = en_cnt; w0 = wr_cnt;
    issue(1, 2'b10, 9'h005, 16'h00AA, 16'h00FF, g);
    wait_rsp(20, n);
    checks++; if ({n == 4, rsp_data, rsp_err} !== {1'b1, 16'hFFAA, 1'b0}) begin
      errors++; $display("FAIL rmw_rsp: got n=%0d data=%h err=%b want 4 FFAA 0", n, rsp_data, rsp_err); end
    checks++; if ((en_cnt - e0) != 2 || (wr_cnt - w0) != 1 || last_di !== 16'hFFAA || mem[9'h005] !== 16'hFFAA) begin
      errors++; $display("FAIL rmw_drp: got en=%0d wr=%0d di=%h mem=%h want 2 1 FFAA FFAA", en_cnt - e0, wr_cnt - w0, last_di, mem[9'h005]); end
  endtask

  task automatic test_round_robin();
    logic [1:0] gv [4]; int gt [4]; int ng; int clash; int n;
    rdy_k = 1; ng = 0; clash = 0;
    @(negedge clk);
    req_op = 4'b0000; req_addr = {9'h1A0, 9'h012}; req_valid = 2'b11;
    for (int cyc = 0; cyc < 60 && ng < 4; cyc++) begin
      #1;
      if (req_ready != 2'b00) begin
        if (rsp_valid) clash++;
        gv[ng] = req_ready; gt[ng] = cyc; ng++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    checks++; if (ng != 4) begin errors++; $display("FAIL rr_count: got %0d grants want 4", ng); end
    checks++; if ({gv[0], gv[1], gv[2], gv[3]} !== 8'b01_10_01_10) begin
      errors++; $display("FAIL rr_order: got %b %b %b %b want 01 10 01 10", gv[0], gv[1], gv[2], gv[3]); end
    checks++; if (gt[1] - gt[0] != 4 || gt[2] - gt[1] != 4 || gt[3] - gt[2] != 4 || clash != 0) begin
      errors++; $display("FAIL rr_spacing: got %0d %0d %0d clash=%0d want 4 4 4 clash=0", gt[1]-gt[0], gt[2]-gt[1], gt[3]-gt[2], clash); end
    wait_rsp(20, n);
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [1:0] g; int n; int e0, w0;
    no_rdy = 1'b1;
    issue(0, 2'b00, 9'h012, 16'h0, 16'h0, g);
    wait_rsp(40, n);
    checks++; if ({n == TO + 1, rsp_ch, rsp_data, rsp_err} !== {1'b1, 1'b0, 16'h0000, 1'b1}) begin
      errors++; $display("FAIL to_read: got n=%0d ch=%0d data=%h err=%b want %0d 0 0000 1", n, rsp_ch, rsp_data, rsp_err, TO + 1); end
    e0 = en_cnt; w0 = wr_cnt;
    issue(1, 2'b10, 9'h005, 16'h0F0F, 16'hFFFF, g);
    wait_rsp(40, n);
    checks++; if ({n == TO + 1, rsp_err, rsp_data} !== {1'b1, 1'b1, 16'h0000} || (en_cnt - e0) != 1 || (wr_cnt - w0) != 0 || mem[9'h005] !== 16'hFFAA) begin
      errors++; $display("FAIL to_rmw: got n=%0d err=%b data=%h en=%0d wr=%0d mem=%h want %0d 1 0000 1 0 FFAA",
        n, rsp_err, rsp_data, en_cnt - e0, wr_cnt - w0, mem[9'h005], TO + 1); end
    @(negedge clk);
    late_rdy = 1'b1;
    @(negedge clk);
    late_rdy = 1'b0;
    #1;
    checks++; if ({busy, rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL late_rdy_idle: got busy=%b vld=%b want 0 0", busy, rsp_valid); end
    no_rdy = 1'b0; rdy_k = 2;
    issue(0, 2'b00, 9'h1A0, 16'h0, 16'h0, g);
    late_rdy = 1'b1;   // strobe coinciding with drp_en must be ignored
    @(negedge clk);
    late_rdy = 1'b0;
    wait_rsp(20, n);
    checks++; if ({n == 2, rsp_data, rsp_err} !== {1'b1, 16'h1234, 1'b0}) begin
      errors++; $display("FAIL after_to_read: got n=%0d data=%h err=%b want 2 1234 0", n, rsp_data, rsp_err); end
  endtask

  task automatic test_reserved_and_reset();
    int n; int e0; int seen;
    rdy_k = 1; e0 = en_cnt;
    @(negedge clk);
    req_op = 4'b0011; req_addr = {9'h012, 9'h000}; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rsv_grant: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    checks++; if ({rsp_valid, rsp_err, rsp_data, rsp_ch, drp_en, req_ready} !== {1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 2'b00}) begin
      errors++; $display("FAIL rsv_rsp: got vld=%b err=%b data=%h ch=%0d en=%b ready=%b want 1 1 0000 0 0 00",
        rsp_valid, rsp_err, rsp_data, rsp_ch, drp_en, req_ready); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL post_resp_grant: got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(20, n);
    checks++; if ({rsp_data, rsp_err} !== {16'hBEEF, 1'b0} || (en_cnt - e0) != 1) begin
      errors++; $display("FAIL rsv_next: got data=%h err=%b en=%0d want BEEF 0 1", rsp_data, rsp_err, en_cnt - e0); end
    @(negedge clk);
    no_rdy = 1'b1;
    begin
      logic [1:0] g;
      issue(0, 2'b00, 9'h012, 16'h0, 16'h0, g);
    end
    @(negedge clk); @(negedge clk);
    sys_rst_n = 1'b0;
    #1;
    checks++; if ({drp_en, drp_addr, busy, rsp_valid, rsp_data, req_ready} !== '0) begin
      errors++; $display("FAIL mid_reset: got en=%b addr=%h busy=%b vld=%b data=%h ready=%b want all 0",
        drp_en, drp_addr, busy, rsp_valid, rsp_data, req_ready); end
    @(negedge clk); @(negedge clk);
    sys_rst_n = 1'b1; no_rdy = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_rmw();
    test_round_robin();
    test_timeout();
    test_reserved_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
